// File: rtl/reg_file32_if.sv
// reg_file32_if: register-file access bus.
// Carries the two read selects and their returned data, plus the single
// write port (select, data, enable). Clock and reset stay outside the bus.
interface reg_file32_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] Read1;
  logic [ADDR_WIDTH-1:0] Read2;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic [DATA_WIDTH-1:0] Data1;
  logic [DATA_WIDTH-1:0] Data2;

  // Decode/writeback side: drives selects and write data, receives read data.
  modport master (
    output Read1,
    output Read2,
    output WriteReg,
    output WriteData,
    output RegWrite,
    input  Data1,
    input  Data2
  );

  // Register-file side.
  modport slave (
    input  Read1,
    input  Read2,
    input  WriteReg,
    input  WriteData,
    input  RegWrite,
    output Data1,
    output Data2
  );

endinterface

// File: rtl/reg_file32.sv
// reg_file32: 2**ADDR_WIDTH x DATA_WIDTH general-purpose register file.
// Two combinational read ports, one synchronous write port, optional
// hardwired-zero register 0 (ZERO_REG).
// Optional feature macro: REGFILE_WRITE_BYPASS_EN -- when defined, each read
// port forwards WriteData in the same cycle if it selects the register being
// written (write-through). Without it, reads show stored contents only.
module reg_file32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic          clock,
  input  logic          reset,
  reg_file32_if.slave   bus
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_allowed;
  logic [DATA_WIDTH-1:0] rd1_data;
  logic [DATA_WIDTH-1:0] rd2_data;

  // A write is accepted unless it targets the hardwired-zero register.
  always_comb begin
    wr_allowed = bus.RegWrite;
    if (ZERO_EN && (bus.WriteReg == '0)) begin
      wr_allowed = 1'b0;
    end
  end

  // Next-state of the storage array: hold everything, update the one target.
  always_comb begin
    regs_d = regs_q;
    if (wr_allowed) begin
      regs_d[bus.WriteReg] = bus.WriteData;
    end
  end

  // Storage: asynchronous clear so reads drop to zero without a clock edge;
  // a write is therefore impossible while reset is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: stored value, masked for register 0, optional forwarding.
  always_comb begin
    rd1_data = regs_q[bus.Read1];
    if (ZERO_EN && (bus.Read1 == '0)) begin
      rd1_data = '0;
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_allowed && !reset && (bus.Read1 == bus.WriteReg)) begin
      rd1_data = bus.WriteData;
    end
`endif
  end

  // Read port 2: identical to port 1, evaluated independently.
  always_comb begin
    rd2_data = regs_q[bus.Read2];
    if (ZERO_EN && (bus.Read2 == '0)) begin
      rd2_data = '0;
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_allowed && !reset && (bus.Read2 == bus.WriteReg)) begin
      rd2_data = bus.WriteData;
    end
`endif
  end

  assign bus.Data1 = rd1_data;
  assign bus.Data2 = rd2_data;

endmodule

// File: tb/tb_reg_file32.sv
// tb_reg_file32: directed self-checking bench for reg_file32.
// Expected values follow REGFILE_WRITE_BYPASS_EN when the build defines it.
module tb_reg_file32;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] vals [32];

  reg_file32_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_file32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single write, driven at the falling edge, committed at the next rising edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.WriteReg  = a;
    bus.WriteData = d;
    bus.RegWrite  = 1'b1;
    @(posedge clock);
    #1;
    bus.RegWrite  = 1'b0;
  endtask

  task automatic test_reset();
    // Power-on reset state
    bus.Read1 = 5'd5;
    bus.Read2 = 5'd31;
    #1;
    checks++;
    if (bus.Data1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_init_d1: got %h want %h", bus.Data1, 32'h0);
    end
    checks++;
    if (bus.Data2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_init_d2: got %h want %h", bus.Data2, 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    do_write(5'd5, 32'hDEADBEEF);
    @(negedge clock);
    #1;
    checks++;
    if (bus.Data1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_prewrite: got %h want %h", bus.Data1, 32'hDEADBEEF);
    end
    // Asynchronous pulse mid-cycle, no clock edge in between
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.Data1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", bus.Data1, 32'h0);
    end
    // Write attempted across an edge while reset is held
    bus.WriteReg  = 5'd5;
    bus.WriteData = 32'hCAFEF00D;
    bus.RegWrite  = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus.Data1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_blocks_write: got %h want %h", bus.Data1, 32'h0);
    end
    bus.RegWrite = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.Data1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", bus.Data1, 32'h0);
    end
  endtask

  task automatic test_write_all();
    for (int i = 0; i < 32; i++) begin
      vals[i] = (32'h01010101 * i) ^ 32'h5A3C0F96;
      do_write(5'(i), vals[i]);
    end
    for (int i = 0; i < 32; i += 2) begin
      @(negedge clock);
      bus.Read1 = 5'(i);
      bus.Read2 = 5'(i + 1);
      #1;
      checks++;
      if (bus.Data1 !== ((i == 0) ? 32'h0 : vals[i])) begin
        errors++;
        $display("FAIL write_all_d1 reg %0d: got %h want %h", i, bus.Data1,
                 (i == 0) ? 32'h0 : vals[i]);
      end
      checks++;
      if (bus.Data2 !== vals[i+1]) begin
        errors++;
        $display("FAIL write_all_d2 reg %0d: got %h want %h", i + 1, bus.Data2, vals[i+1]);
      end
    end
  endtask

  task automatic test_write_disable();
    @(negedge clock);
    bus.RegWrite  = 1'b0;
    bus.WriteReg  = 5'd7;
    bus.WriteData = 32'h12345678;
    bus.Read1     = 5'd7;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.Data1 !== vals[7]) begin
      errors++;
      $display("FAIL write_disable: got %h want %h", bus.Data1, vals[7]);
    end
  endtask

  task automatic test_dual_read();
    do_write(5'd9, 32'hA5A5A5A5);
    @(negedge clock);
    bus.Read1 = 5'd9;
    bus.Read2 = 5'd9;
    #1;
    checks++;
    if (bus.Data1 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL dual_read_d1: got %h want %h", bus.Data1, 32'hA5A5A5A5);
    end
    checks++;
    if (bus.Data2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL dual_read_d2: got %h want %h", bus.Data2, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] exp_pre;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_pre = 32'h22222222;
`else
    exp_pre = 32'h11111111;
`endif
    do_write(5'd3, 32'h11111111);
    @(negedge clock);
    bus.Read1     = 5'd3;
    bus.Read2     = 5'd4;
    bus.WriteReg  = 5'd3;
    bus.WriteData = 32'h22222222;
    bus.RegWrite  = 1'b1;
    #1;
    checks++;
    if (bus.Data1 !== exp_pre) begin
      errors++;
      $display("FAIL rdw_before_edge: got %h want %h", bus.Data1, exp_pre);
    end
    checks++;
    if (bus.Data2 !== vals[4]) begin
      errors++;
      $display("FAIL rdw_other_port: got %h want %h", bus.Data2, vals[4]);
    end
    @(posedge clock);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    checks++;
    if (bus.Data1 !== 32'h22222222) begin
      errors++;
      $display("FAIL rdw_after_edge: got %h want %h", bus.Data1, 32'h22222222);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clock);
    bus.Read1     = 5'd0;
    bus.Read2     = 5'd0;
    bus.WriteReg  = 5'd0;
    bus.WriteData = 32'hFFFFFFFF;
    bus.RegWrite  = 1'b1;
    #1;
    checks++;
    if (bus.Data1 !== 32'h0) begin
      errors++;
      $display("FAIL zero_pre_d1: got %h want %h", bus.Data1, 32'h0);
    end
    checks++;
    if (bus.Data2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_pre_d2: got %h want %h", bus.Data2, 32'h0);
    end
    @(posedge clock);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    checks++;
    if (bus.Data1 !== 32'h0) begin
      errors++;
      $display("FAIL zero_post_d1: got %h want %h", bus.Data1, 32'h0);
    end
    checks++;
    if (bus.Data2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_post_d2: got %h want %h", bus.Data2, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    do_write(5'd12, 32'h0BADF00D);
    do_write(5'd13, 32'hFEEDFACE);
    do_write(5'd12, 32'h13579BDF);
    @(negedge clock);
    bus.Read1 = 5'd12;
    bus.Read2 = 5'd13;
    #1;
    checks++;
    if (bus.Data1 !== 32'h13579BDF) begin
      errors++;
      $display("FAIL b2b_d1: got %h want %h", bus.Data1, 32'h13579BDF);
    end
    checks++;
    if (bus.Data2 !== 32'hFEEDFACE) begin
      errors++;
      $display("FAIL b2b_d2: got %h want %h", bus.Data2, 32'hFEEDFACE);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.Read1     = '0;
    bus.Read2     = '0;
    bus.WriteReg  = '0;
    bus.WriteData = '0;
    bus.RegWrite  = 1'b0;
    test_reset();
    test_write_all();
    test_write_disable();
    test_dual_read();
    test_read_during_write();
    test_zero_reg();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
